// File: rtl/alu_sequencer.sv
// Multi-cycle controller around the 4-bit decode-and-execute ALU: owns a 4x4 register
// file, accepts one instruction per valid/ready handshake and writes the result back.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] op_code,
  input  logic [1:0] rs_addr,
  input  logic [1:0] rt_addr,
  input  logic [1:0] rd_addr,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  output logic       done,
  output logic [3:0] result,
  output logic [1:0] result_addr,
  output logic [7:0] instr_cnt,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the source holds valid and payload stable until that edge. Loads win over instructions.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] regs [4];
  logic [2:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] alu_q;
  logic [1:0] rd_q;
  logic [3:0] alu_rd;
  logic       do_load;
  logic       do_accept;

  // Combinational ALU; all results wrap modulo 16. The 4-bit multiply is exactly the
  // low nibble of the full 8-bit product.
  always_comb begin
    alu_rd = '0;
    case (op_q)
      3'b000:  alu_rd = a_q + b_q;
      3'b001:  alu_rd = a_q + ~b_q + 4'd1;
      3'b010:  alu_rd = a_q + 4'd1;
      3'b011:  alu_rd = ~(a_q | b_q);
      3'b100:  alu_rd = ~(a_q & b_q);
      3'b101:  alu_rd = a_q >> 2;
      3'b110:  alu_rd = a_q << 1;
      3'b111:  alu_rd = a_q * b_q;
      default: alu_rd = '0;
    endcase
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    do_load     = 1'b0;
    do_accept   = 1'b0;
    case (state)
      IDLE: begin
        ld_ready    = 1'b1;
        instr_ready = !ld_valid;
        do_load     = ld_valid;
        if (instr_valid && !ld_valid) begin
          do_accept  = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operands are captured at accept, so rd aliasing rs/rt sees pre-write values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      alu_q <= '0;
    end else begin
      if (do_accept) begin
        op_q <= op_code;
        a_q  <= regs[rs_addr];
        b_q  <= regs[rt_addr];
        rd_q <= rd_addr;
      end
      if (state == EXEC) alu_q <= alu_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      result      <= '0;
      result_addr <= '0;
      done        <= 1'b0;
      instr_cnt   <= '0;
    end else begin
      done <= (state == WB);
      if (do_load) regs[ld_addr] <= ld_data;
      if (state == WB) begin
        regs[rd_q]  <= alu_q;
        result      <= alu_q;
        result_addr <= rd_q;
        instr_cnt   <= instr_cnt + 8'd1;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table-driven ALU vectors, hand-written multi-cycle sequences
// and a random run through the instr_cnt wrap, checked against a scoreboard queue.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op_code;
  logic [1:0] rs_addr;
  logic [1:0] rt_addr;
  logic [1:0] rd_addr;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic       done;
  logic [3:0] result;
  logic [1:0] result_addr;
  logic [7:0] instr_cnt;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_code(op_code), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .done(done), .result(result), .result_addr(result_addr), .instr_cnt(instr_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] exp_q[$];
  logic [3:0] model[4];
  logic [7:0] exp_cnt;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_r;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    case (op)
      3'd0:    return 4'((ai + bi) % 16);
      3'd1:    return 4'((ai - bi + 16) % 16);
      3'd2:    return 4'((ai + 1) % 16);
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return 4'(ai / 4);
      3'd6:    return 4'((ai * 2) % 16);
      default: return 4'((ai * bi) % 16);
    endcase
  endfunction

  task automatic do_load(input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    check("ld_ready_idle", ld_ready, 1);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    @(posedge clk);
    #1 ld_valid = 1'b0;
    model[addr] = data;
  endtask

  // Called right after the accept edge; expects done on the third following negedge.
  task automatic wait_result();
    int         lat;
    logic [5:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done && lat <= 2) begin
        check("instr_ready_busy", instr_ready, 0);
        check("ld_ready_busy", ld_ready, 0);
      end
    end while (!done && lat < 8);
    check("done_latency", 8'(lat), 3);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      dbg_addr = e[5:4];
      #1;
      check("result", result, e[3:0]);
      check("result_addr", result_addr, e[5:4]);
      check("dbg_rd", dbg_data, e[3:0]);
      check("instr_cnt", instr_cnt, exp_cnt);
      check("instr_ready_after", instr_ready, 1);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input logic [3:0] exp_r);
    int w;
    @(negedge clk);
    op_code     = op;
    rs_addr     = rs;
    rt_addr     = rt;
    rd_addr     = rd;
    instr_valid = 1'b1;
    w = 0;
    #1;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", instr_ready, 1);
    exp_q.push_back({rd, exp_r});
    model[rd] = exp_r;
    exp_cnt++;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_result();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 4'h5, 4'h3, 4'h8};
    vecs[1]  = '{3'd0, 4'hF, 4'h1, 4'h0};
    vecs[2]  = '{3'd1, 4'h3, 4'h5, 4'hE};
    vecs[3]  = '{3'd1, 4'h0, 4'h1, 4'hF};
    vecs[4]  = '{3'd2, 4'hF, 4'h0, 4'h0};
    vecs[5]  = '{3'd7, 4'h7, 4'h3, 4'h5};
    vecs[6]  = '{3'd7, 4'hF, 4'hF, 4'h1};
    vecs[7]  = '{3'd4, 4'hC, 4'hA, 4'h7};
    vecs[8]  = '{3'd3, 4'hC, 4'hA, 4'h1};
    vecs[9]  = '{3'd5, 4'hC, 4'h0, 4'h3};
    vecs[10] = '{3'd5, 4'hF, 4'h0, 4'h3};
    vecs[11] = '{3'd6, 4'h5, 4'h0, 4'hA};
    vecs[12] = '{3'd6, 4'h8, 4'h0, 4'h0};

    rst = 1'b1;
    instr_valid = 1'b0;
    op_code = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    exp_cnt = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_instr_ready", instr_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_result_addr", result_addr, 0);
    check("rst_instr_cnt", instr_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 check("rst_reg", dbg_data, 0);
    end
    rst = 1'b0;

    // Reset mid-EXEC of add R0=R1+R2 aborts the instruction
    do_load(2'd1, 4'h5);
    @(negedge clk);
    op_code = 3'd0; rs_addr = 2'd1; rt_addr = 2'd2; rd_addr = 2'd0;
    instr_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    dbg_addr = 2'd0;
    #1;
    check("abort_r0", dbg_data, 0);
    check("abort_cnt", instr_cnt, 0);
    check("abort_ready", instr_ready, 1);

    // Load R1=5, R2=3; add R0
    do_load(2'd1, 4'h5);
    do_load(2'd2, 4'h3);
    issue(3'd0, 2'd1, 2'd2, 2'd0, 4'h8);

    // Table of ALU vectors through R1/R2 -> R3
    for (int i = 0; i < 13; i++) begin
      do_load(2'd1, vecs[i].a);
      do_load(2'd2, vecs[i].b);
      issue(vecs[i].op, 2'd1, 2'd2, 2'd3, vecs[i].exp_r);
    end

    // rd = rs reuse: shl R1=R1 twice from 1
    do_load(2'd1, 4'h1);
    issue(3'd6, 2'd1, 2'd1, 2'd1, 4'h2);
    issue(3'd6, 2'd1, 2'd1, 2'd1, 4'h4);

    // Simultaneous load and instruction: load first, then add R3 = R1(=9) + R2
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 4'h9;
    op_code = 3'd0; rs_addr = 2'd1; rt_addr = 2'd2; rd_addr = 2'd3;
    instr_valid = 1'b1;
    #1;
    check("both_instr_ready", instr_ready, 0);
    check("both_ld_ready", ld_ready, 1);
    @(posedge clk);
    #1 ld_valid = 1'b0;
    model[1] = 4'h9;
    @(negedge clk);
    check("both_ready_next", instr_ready, 1);
    exp_q.push_back({2'd3, 4'(model[1] + model[2])});
    model[3] = 4'(model[1] + model[2]);
    exp_cnt++;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_result();

    // Random instructions until instr_cnt wraps past 255
    for (int n = 0; n < 300 && exp_cnt != 8'd0; n++) begin
      logic [2:0] op;
      logic [1:0] rs;
      logic [1:0] rt;
      logic [1:0] rd;
      if ($urandom_range(0, 3) == 0) do_load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      op = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      rt = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      issue(op, rs, rt, rd, alu_model(op, model[rs], model[rt]));
    end
    check("wrap_cnt", instr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the team's 4-bit gate-level decode-and-execute ALU. It owns a 4-entry × 4-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads the operands, drives the ALU, and writes the result back. It sits between the lab's instruction source (testbench or FPGA switch logic) and the combinational ALU instance, which it contains.

## Interface
- No parameters; widths fixed: data 4 bits, register address 2 bits, opcode 3 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction present on op_code/rs_addr/rt_addr/rd_addr
- instr_ready  output  1  controller can accept an instruction this cycle
- op_code  input  3  ALU operation; encoding identical to the ALU:
  - 000 add, 001 sub, 010 increment, 011 NOR, 100 NAND
  - 101 shift right by 2, 110 shift left by 1, 111 multiply (low nibble)
- rs_addr, rt_addr, rd_addr  input  2 each  source/destination register indices
- ld_valid  input  1  request to write ld_data into register ld_addr
- ld_ready  output  1  load can be accepted this cycle
- ld_addr  input  2  load destination
- ld_data  input  4  load value
- done  output  1  one-cycle pulse when a result is written back
- result  output  4  value written back, held until next writeback
- result_addr  output  2  register written, held with result
- instr_cnt  output  8  number of completed instructions, wraps 255→0
- dbg_addr  input  2  debug read index
- dbg_data  output  4  combinational read of register dbg_addr

## Operation
- States: IDLE, EXEC, WB. Encoded in 2 bits; the unused code returns to IDLE.
- In IDLE:
  - ld_ready=1.
  - instr_ready = !ld_valid (loads have priority).
- In EXEC and WB: instr_ready=0 and ld_ready=0.
- Load: in IDLE with ld_valid=1, regs[ld_addr]←ld_data at the edge. State stays IDLE. No done pulse, no instr_cnt change.
- Accept (IDLE, instr_valid && instr_ready), at the edge:
  - op_q←op_code.
  - a_q←regs[rs_addr], b_q←regs[rt_addr].
  - rd_q←rd_addr.
  - state→EXEC.
- EXEC: ALU is driven from op_q/a_q/b_q; alu_q←ALU rd at the edge; state→WB.
- WB, at the edge:
  - regs[rd_q]←alu_q; result←alu_q; result_addr←rd_q.
  - instr_cnt←instr_cnt+1 (mod 256).
  - state→IDLE.
- done is high during the cycle after the WB edge, i.e. registered alongside result.
- Arithmetic: every result is modulo 16, with no carry or overflow output.
  - sub = rs + ~rt + 1.
  - increment = rs + 1.
  - multiply returns p[3:0] of the 8-bit product.
- Operands are captured at accept. rd_addr equal to rs_addr or rt_addr is legal and uses the pre-write values.
- Inputs not sampled outside IDLE are ignored. The source must hold instr_valid until accepted; there is no skid buffer.
- dbg_data reflects register writes from the cycle after the write edge.

## Timing
- Reset values:
  - state=IDLE.
  - regs all 0, op_q/a_q/b_q/alu_q/rd_q=0.
  - result=0, result_addr=0, done=0, instr_cnt=0.
  - instr_ready=1 and ld_ready=1 (after reset, with ld_valid=0).
- Latency: instruction accepted at edge N → EXEC in cycle N..N+1 → WB at edge N+2 → done=1 in cycle N+2..N+3, and register updated then.
- Throughput: one instruction per 3 cycles. The next accept can occur at edge N+3.
- Simultaneous ld_valid and instr_valid in IDLE: only the load is taken, and the instruction waits one or more cycles.
- rst asserted in EXEC or WB: the instruction is aborted, with no writeback, no done, and no count. Reset takes effect immediately and asynchronously.
- rst deasserted: the first accept is possible at the first rising edge with rst=0.
- instr_cnt 255 + one completion → 0. done still pulses.

## Test plan
- Reset mid-EXEC of add R0=R1+R2 (R1=5) → R0 stays 0, done never pulses, instr_cnt=0, instr_ready=1 next cycle.
- Load R1=5, R2=3; add rd=R0 → done 3 cycles after accept, result=8, result_addr=0, dbg R0=8, instr_cnt=1.
- Sub R3=R2−R1 (3−5) → result=4'hE. Increment R1=F → result=0 (wrap).
- Multiply 7×3 → result=5 (low nibble of 21). NAND 4'b1100,4'b1010 → 4'b0111. NOR → 4'b0001.
- Shift right-2 rs=4'b1100 → 4'b0011. Shift left-1 rs=4'b0101 → 4'b1010. rd=rs reuse: shl R1=R1 twice from 1 → 2 then 4.
- ld_valid and instr_valid together in IDLE → load written, instr_ready=0 that cycle, instruction accepted the next cycle using the loaded value. Run 256 instructions → instr_cnt wraps to 0.
